// File: rtl/ascon_serial_ctrl.sv
// ascon_serial_ctrl: command/result front end for the bit-serial ASCON-128 core.
// One accepted command runs the whole core sequence: core reset, MSB-first
// serial load of key/nonce/AD/data, start pulse, wait for ready (with timeout),
// a short settle gap, then LSB-first readout of the output text and the tag.
module ascon_serial_ctrl #(
    parameter int K            = 128,
    parameter int Y            = 104,
    parameter int L            = 40,
    parameter int RST_CYCLES   = 2,
    parameter int START_CYCLES = 3,
    parameter int READ_GAP     = 2,
    parameter int TIMEOUT      = 4096
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           cmd_valid,
    output logic           cmd_ready,
    input  logic           cmd_decrypt,
    input  logic [K-1:0]   cmd_key,
    input  logic [127:0]   cmd_nonce,
    input  logic [L-1:0]   cmd_ad,
    input  logic [Y-1:0]   cmd_data,
    output logic           res_valid,
    input  logic           res_ready,
    output logic [Y-1:0]   res_data,
    output logic [127:0]   res_tag,
    output logic           res_err,
    output logic           busy,
    output logic           core_rst,
    output logic           core_key_si,
    output logic           core_nonce_si,
    output logic           core_ad_si,
    output logic           core_data_si,
    output logic           core_start,
    output logic           core_decrypt,
    input  logic           core_data_so,
    input  logic           core_tag_so,
    input  logic           core_ready
);

    localparam int MAXW_KY  = (K > Y) ? K : Y;
    localparam int MAXW_KYL = (MAXW_KY > L) ? MAXW_KY : L;
    localparam int MAXW     = (MAXW_KYL > 128) ? MAXW_KYL : 128;
    localparam int CW       = $clog2(MAXW + 1);
    localparam int WW       = $clog2(TIMEOUT + 1);

    // Terminal counts, pre-sized to the counter widths they are compared with.
    localparam logic [CW-1:0] RST_LAST   = CW'(RST_CYCLES - 1);
    localparam logic [CW-1:0] START_LAST = CW'(START_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LAST   = CW'(READ_GAP - 1);
    localparam logic [CW-1:0] BIT_LAST   = CW'(MAXW - 1);
    localparam logic [CW-1:0] Y_BITS     = CW'(Y);
    localparam logic [CW-1:0] TAG_BITS   = CW'(128);
    localparam logic [WW-1:0] WAIT_LAST  = WW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CRST  = 3'd1,
        S_LOAD  = 3'd2,
        S_START = 3'd3,
        S_WAIT  = 3'd4,
        S_GAP   = 3'd5,
        S_READ  = 3'd6,
        S_DONE  = 3'd7
    } state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;          // shared phase / bit counter
    logic [WW-1:0]  wcnt_q, wcnt_d;        // WAIT cycle counter

    // Load shift registers: the MSB is always the bit being presented, and
    // zeros shift in from the bottom so a line past its width drives 0.
    logic [K-1:0]   key_sr_q, key_sr_d;
    logic [127:0]   nonce_sr_q, nonce_sr_d;
    logic [L-1:0]   ad_sr_q, ad_sr_d;
    logic [Y-1:0]   data_sr_q, data_sr_d;

    logic           cmd_ready_q, cmd_ready_d;
    logic           res_valid_q, res_valid_d;
    logic [Y-1:0]   res_data_q, res_data_d;
    logic [127:0]   res_tag_q, res_tag_d;
    logic           res_err_q, res_err_d;
    logic           busy_q, busy_d;
    logic           core_rst_q, core_rst_d;
    logic           key_si_q, key_si_d;
    logic           nonce_si_q, nonce_si_d;
    logic           ad_si_q, ad_si_d;
    logic           data_si_q, data_si_d;
    logic           core_start_q, core_start_d;
    logic           core_decrypt_q, core_decrypt_d;

    // Next-state, counters, shift registers and next values of every output.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        wcnt_d         = wcnt_q;
        key_sr_d       = key_sr_q;
        nonce_sr_d     = nonce_sr_q;
        ad_sr_d        = ad_sr_q;
        data_sr_d      = data_sr_q;
        res_data_d     = res_data_q;
        res_tag_d      = res_tag_q;
        res_err_d      = res_err_q;
        core_decrypt_d = core_decrypt_q;

        case (state_q)
            S_IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    key_sr_d       = cmd_key;
                    nonce_sr_d     = cmd_nonce;
                    ad_sr_d        = cmd_ad;
                    data_sr_d      = cmd_data;
                    core_decrypt_d = cmd_decrypt;
                    res_err_d      = 1'b0;
                    cnt_d          = '0;
                    state_d        = S_CRST;
                end
            end
            S_CRST: begin
                if (cnt_q == RST_LAST) begin
                    cnt_d   = '0;
                    state_d = S_LOAD;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_LOAD: begin
                // Advance to the next bit; the last shift is harmless since
                // the lines are forced low outside LOAD.
                key_sr_d   = {key_sr_q[K-2:0], 1'b0};
                nonce_sr_d = {nonce_sr_q[126:0], 1'b0};
                ad_sr_d    = {ad_sr_q[L-2:0], 1'b0};
                data_sr_d  = {data_sr_q[Y-2:0], 1'b0};
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    state_d = S_START;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_START: begin
                if (cnt_q == START_LAST) begin
                    wcnt_d  = '0;
                    state_d = S_WAIT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_WAIT: begin
                // Ready wins over the timeout when both land on the same cycle.
                if (core_ready) begin
                    cnt_d   = '0;
                    state_d = S_GAP;
                end else if (wcnt_q == WAIT_LAST) begin
                    res_err_d  = 1'b1;
                    res_data_d = '0;
                    res_tag_d  = '0;
                    state_d    = S_DONE;
                end else begin
                    wcnt_d = wcnt_q + 1'b1;
                end
            end
            S_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    cnt_d   = '0;
                    state_d = S_READ;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_READ: begin
                // LSB first: each new bit enters at the top and walks down, so
                // after Y (resp. 128) shifts bit r sits at index r.
                if (cnt_q < Y_BITS) begin
                    res_data_d = {core_data_so, res_data_q[Y-1:1]};
                end
                if (cnt_q < TAG_BITS) begin
                    res_tag_d = {core_tag_so, res_tag_q[127:1]};
                end
                if (cnt_q == BIT_LAST) begin
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DONE: begin
                if (res_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Outputs are registered alongside the state they belong to.
        cmd_ready_d  = (state_d == S_IDLE);
        busy_d       = (state_d != S_IDLE);
        res_valid_d  = (state_d == S_DONE);
        core_rst_d   = (state_d == S_CRST);
        core_start_d = (state_d == S_START);
        key_si_d     = (state_d == S_LOAD) & key_sr_d[K-1];
        nonce_si_d   = (state_d == S_LOAD) & nonce_sr_d[127];
        ad_si_d      = (state_d == S_LOAD) & ad_sr_d[L-1];
        data_si_d    = (state_d == S_LOAD) & data_sr_d[Y-1];
    end

    // Single state/output register bank; reset parks the core in reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_IDLE;
            cnt_q          <= '0;
            wcnt_q         <= '0;
            key_sr_q       <= '0;
            nonce_sr_q     <= '0;
            ad_sr_q        <= '0;
            data_sr_q      <= '0;
            cmd_ready_q    <= 1'b0;
            res_valid_q    <= 1'b0;
            res_data_q     <= '0;
            res_tag_q      <= '0;
            res_err_q      <= 1'b0;
            busy_q         <= 1'b0;
            core_rst_q     <= 1'b1;
            key_si_q       <= 1'b0;
            nonce_si_q     <= 1'b0;
            ad_si_q        <= 1'b0;
            data_si_q      <= 1'b0;
            core_start_q   <= 1'b0;
            core_decrypt_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            wcnt_q         <= wcnt_d;
            key_sr_q       <= key_sr_d;
            nonce_sr_q     <= nonce_sr_d;
            ad_sr_q        <= ad_sr_d;
            data_sr_q      <= data_sr_d;
            cmd_ready_q    <= cmd_ready_d;
            res_valid_q    <= res_valid_d;
            res_data_q     <= res_data_d;
            res_tag_q      <= res_tag_d;
            res_err_q      <= res_err_d;
            busy_q         <= busy_d;
            core_rst_q     <= core_rst_d;
            key_si_q       <= key_si_d;
            nonce_si_q     <= nonce_si_d;
            ad_si_q        <= ad_si_d;
            data_si_q      <= data_si_d;
            core_start_q   <= core_start_d;
            core_decrypt_q <= core_decrypt_d;
        end
    end

    assign cmd_ready     = cmd_ready_q;
    assign res_valid     = res_valid_q;
    assign res_data      = res_data_q;
    assign res_tag       = res_tag_q;
    assign res_err       = res_err_q;
    assign busy          = busy_q;
    assign core_rst      = core_rst_q;
    assign core_key_si   = key_si_q;
    assign core_nonce_si = nonce_si_q;
    assign core_ad_si    = ad_si_q;
    assign core_data_si  = data_si_q;
    assign core_start    = core_start_q;
    assign core_decrypt  = core_decrypt_q;

endmodule

// File: tb/tb_ascon_serial_ctrl.sv
// Bench for ascon_serial_ctrl: a behavioural serial-core stand-in (toy cipher,
// XOR keystream + linear tag) plus per-scenario tasks with inline checks.
module tb_ascon_serial_ctrl;
    localparam int K = 128;
    localparam int Y = 104;
    localparam int L = 40;

    localparam logic [K-1:0]   VEC_KEY   = 128'h6d4f8bbf60ec05a07b201d4e5b2119ac;
    localparam logic [127:0]   VEC_NONCE = 128'h05885e606e1271b8d47a74c7b297a318;
    localparam logic [L-1:0]   VEC_AD    = 40'h4153434f4e;
    localparam logic [Y-1:0]   VEC_DATA  = 104'h6173636f6e2d756e6963617373;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic cmd_valid = 1'b0, cmd_decrypt = 1'b0, res_ready = 1'b0;
    logic [K-1:0] cmd_key = '0;
    logic [127:0] cmd_nonce = '0;
    logic [L-1:0] cmd_ad = '0;
    logic [Y-1:0] cmd_data = '0;
    logic cmd_ready, res_valid, res_err, busy;
    logic [Y-1:0] res_data;
    logic [127:0] res_tag;
    logic core_rst, core_key_si, core_nonce_si, core_ad_si, core_data_si;
    logic core_start, core_decrypt, core_data_so, core_tag_so, core_ready;

    int checks = 0;
    int fails  = 0;
    bit no_ready = 1'b0;
    int ready_delay = 0;
    logic [Y-1:0] ct_rec;
    logic [127:0] t_rec;

    always #5 clk = ~clk;

    ascon_serial_ctrl dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_decrypt(cmd_decrypt),
        .cmd_key(cmd_key), .cmd_nonce(cmd_nonce), .cmd_ad(cmd_ad), .cmd_data(cmd_data),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_tag(res_tag), .res_err(res_err), .busy(busy),
        .core_rst(core_rst), .core_key_si(core_key_si), .core_nonce_si(core_nonce_si),
        .core_ad_si(core_ad_si), .core_data_si(core_data_si), .core_start(core_start),
        .core_decrypt(core_decrypt), .core_data_so(core_data_so),
        .core_tag_so(core_tag_so), .core_ready(core_ready)
    );

    // Toy cipher standing in for ASCON: text = data ^ keystream, tag over plaintext.
    function automatic logic [Y-1:0] ref_ks(input logic [K-1:0] k, input logic [127:0] n,
                                            input logic [L-1:0] a);
        return k[Y-1:0] ^ n[Y-1:0] ^ {a, a, a[23:0]};
    endfunction
    function automatic logic [Y-1:0] ref_text(input logic [K-1:0] k, input logic [127:0] n,
                                              input logic [L-1:0] a, input logic [Y-1:0] d);
        return d ^ ref_ks(k, n, a);
    endfunction
    function automatic logic [127:0] ref_tag(input logic dec, input logic [K-1:0] k,
                                             input logic [127:0] n, input logic [L-1:0] a,
                                             input logic [Y-1:0] d);
        logic [Y-1:0] pt;
        pt = dec ? (d ^ ref_ks(k, n, a)) : d;
        return k ^ n ^ {24'h0, pt} ^ {a, 88'h0};
    endfunction

    // Serial core model: shifts in 128 bits after core_rst drops, starts its
    // delay when core_start falls, then holds ready and streams result bits.
    logic [K-1:0] m_key;
    logic [127:0] m_nonce, m_out_t;
    logic [L-1:0] m_ad;
    logic [Y-1:0] m_data, m_out_d;
    int m_ld = 0, m_delay = 0, m_k = 0;
    bit m_seen = 1'b0, m_run = 1'b0, m_ready = 1'b0;

    always @(posedge clk) begin
        if (core_rst === 1'b1) begin
            m_ld <= 0; m_seen <= 1'b0; m_run <= 1'b0; m_ready <= 1'b0; m_k <= 0;
        end else begin
            if (m_ld < 128) begin
                m_key   <= {m_key[K-2:0], core_key_si};
                m_nonce <= {m_nonce[126:0], core_nonce_si};
                if (m_ld < L) m_ad <= {m_ad[L-2:0], core_ad_si};
                if (m_ld < Y) m_data <= {m_data[Y-2:0], core_data_si};
                m_ld <= m_ld + 1;
            end
            if (core_start === 1'b1) m_seen <= 1'b1;
            else if (m_seen && !m_run) begin
                m_run   <= 1'b1;
                m_delay <= ready_delay;
                m_out_d <= ref_text(m_key, m_nonce, m_ad, m_data);
                m_out_t <= ref_tag(core_decrypt, m_key, m_nonce, m_ad, m_data);
            end else if (m_run && !m_ready && !no_ready) begin
                if (m_delay == 0) m_ready <= 1'b1;
                else m_delay <= m_delay - 1;
            end
            if (m_ready) m_k <= m_k + 1;
        end
    end

    // Controller samples bit 0 one edge plus READ_GAP (2) edges after it sees ready.
    assign core_ready   = m_ready;
    assign core_data_so = (m_ready && m_k >= 3 && (m_k - 3) < Y)   ? m_out_d[m_k-3] : 1'b0;
    assign core_tag_so  = (m_ready && m_k >= 3 && (m_k - 3) < 128) ? m_out_t[m_k-3] : 1'b0;

    // Issue one command and walk it to completion, checking the serial stream.
    task automatic run_op(input logic dec, input logic [K-1:0] k, input logic [127:0] n,
                          input logic [L-1:0] a, input logic [Y-1:0] d, input int hold,
                          input bit noise, output logic [Y-1:0] rd, output logic [127:0] rt,
                          output logic re, output int wcyc);
        int w, c, starts, rstc, bad_k, bad_n, bad_a, bad_d, bad_dec, bad_busy, bad_hold;
        bit loading, start_seen, got;
        logic ek, ea, ed;
        c = 0; starts = 0; rstc = 0; bad_k = 0; bad_n = 0; bad_a = 0; bad_d = 0;
        bad_dec = 0; bad_busy = 0; bad_hold = 0; loading = 0; start_seen = 0; got = 0;
        wcyc = 0; rd = '0; rt = '0; re = 1'b0;
        w = 0;
        while (cmd_ready !== 1'b1 && w < 1000) begin @(negedge clk); w++; end
        checks++;
        if (cmd_ready !== 1'b1) begin fails++; $display("FAIL cmd_ready_wait: got %b want 1", cmd_ready); end
        cmd_valid = 1'b1; cmd_decrypt = dec; cmd_key = k; cmd_nonce = n; cmd_ad = a; cmd_data = d;
        @(negedge clk);
        cmd_valid = 1'b0;
        for (int i = 0; i < 6000 && !got; i++) begin
            if (res_valid === 1'b1) got = 1'b1;
            else begin
                if (busy !== 1'b1 || cmd_ready !== 1'b0) bad_busy++;
                if (core_decrypt !== dec) bad_dec++;
                if (!loading) begin
                    if (core_rst === 1'b1) rstc++; else loading = 1'b1;
                end
                if (loading && c < 128) begin
                    ek = k[K-1-c];
                    ea = (c < L) ? a[L-1-c] : 1'b0;
                    ed = (c < Y) ? d[Y-1-c] : 1'b0;
                    if (core_key_si !== ek) bad_k++;
                    if (core_nonce_si !== n[127-c]) bad_n++;
                    if (core_ad_si !== ea) bad_a++;
                    if (core_data_si !== ed) bad_d++;
                    c++;
                end
                if (core_start === 1'b1) begin starts++; start_seen = 1'b1; end
                else if (start_seen) wcyc++;
                if (noise) begin
                    cmd_valid = 1'($urandom_range(0, 1));
                    cmd_data  = ~d;
                end
                @(negedge clk);
            end
        end
        cmd_valid = 1'b0;
        checks++;
        if (!got) begin fails++; $display("FAIL res_valid_wait: no result within 6000 cycles"); end
        checks++;
        if (rstc !== 2) begin fails++; $display("FAIL core_rst_len: got %0d want 2", rstc); end
        checks++;
        if (bad_k + bad_n !== 0) begin fails++; $display("FAIL load_key_nonce: %0d/%0d bad bits want 0", bad_k, bad_n); end
        checks++;
        if (bad_a + bad_d !== 0) begin fails++; $display("FAIL load_ad_data: %0d/%0d bad bits want 0", bad_a, bad_d); end
        checks++;
        if (c !== 128) begin fails++; $display("FAIL load_len: got %0d want 128", c); end
        checks++;
        if (starts !== 3) begin fails++; $display("FAIL start_len: got %0d want 3", starts); end
        checks++;
        if (bad_dec + bad_busy !== 0) begin fails++; $display("FAIL busy_mode: dec %0d busy %0d bad cycles want 0", bad_dec, bad_busy); end
        rd = res_data; rt = res_tag; re = res_err;
        for (int i = 0; i < hold; i++) begin
            if (noise) cmd_valid = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (res_valid !== 1'b1 || res_data !== rd || res_tag !== rt || res_err !== re || cmd_ready !== 1'b0)
                bad_hold++;
        end
        cmd_valid = 1'b0;
        if (hold > 0) begin
            checks++;
            if (bad_hold !== 0) begin fails++; $display("FAIL hold_stable: %0d unstable cycles want 0", bad_hold); end
        end
        checks++;
        if (cmd_ready !== 1'b0) begin fails++; $display("FAIL ready_before_hs: got %b want 0", cmd_ready); end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        checks++;
        if (res_valid !== 1'b0 || cmd_ready !== 1'b1 || busy !== 1'b0)
            begin fails++; $display("FAIL after_hs: valid %b ready %b busy %b want 0 1 0", res_valid, cmd_ready, busy); end
        checks++;
        if (res_data !== rd || res_tag !== rt)
            begin fails++; $display("FAIL idle_retain: data %h want %h", res_data, rd); end
    endtask

    task automatic check_result(input string nm, input logic [Y-1:0] rd, input logic [127:0] rt,
                                input logic re, input logic [Y-1:0] wd, input logic [127:0] wt);
        checks++;
        if (rd !== wd) begin fails++; $display("FAIL %s_data: got %h want %h", nm, rd, wd); end
        checks++;
        if (rt !== wt) begin fails++; $display("FAIL %s_tag: got %h want %h", nm, rt, wt); end
        checks++;
        if (re !== 1'b0) begin fails++; $display("FAIL %s_err: got %b want 0", nm, re); end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b0 || core_rst !== 1'b1)
            begin fails++; $display("FAIL reset_ctl: cmd_ready %b core_rst %b want 0 1", cmd_ready, core_rst); end
        checks++;
        if (res_valid !== 1'b0 || res_err !== 1'b0 || busy !== 1'b0 || core_start !== 1'b0 || core_decrypt !== 1'b0)
            begin fails++; $display("FAIL reset_flags: valid %b err %b busy %b start %b want 0", res_valid, res_err, busy, core_start); end
        checks++;
        if (res_data !== '0 || res_tag !== '0)
            begin fails++; $display("FAIL reset_res: data %h tag %h want 0", res_data, res_tag); end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b1 || core_rst !== 1'b0 || busy !== 1'b0)
            begin fails++; $display("FAIL reset_exit: ready %b core_rst %b busy %b want 1 0 0", cmd_ready, core_rst, busy); end
    endtask

    task automatic test_encrypt();
        logic [Y-1:0] rd; logic [127:0] rt; logic re; int wc;
        ready_delay = 5;
        ct_rec = ref_text(VEC_KEY, VEC_NONCE, VEC_AD, VEC_DATA);
        t_rec  = ref_tag(1'b0, VEC_KEY, VEC_NONCE, VEC_AD, VEC_DATA);
        run_op(1'b0, VEC_KEY, VEC_NONCE, VEC_AD, VEC_DATA, 0, 1'b0, rd, rt, re, wc);
        check_result("encrypt", rd, rt, re, ct_rec, t_rec);
    endtask

    task automatic test_decrypt();
        logic [Y-1:0] rd; logic [127:0] rt; logic re; int wc;
        ready_delay = 0;
        run_op(1'b1, VEC_KEY, VEC_NONCE, VEC_AD, ct_rec, 0, 1'b0, rd, rt, re, wc);
        check_result("decrypt", rd, rt, re, VEC_DATA, t_rec);
    endtask

    task automatic test_backpressure();
        logic [Y-1:0] rd, d; logic [127:0] rt, n; logic [K-1:0] k; logic [L-1:0] a; logic re; int wc;
        k = {$urandom, $urandom, $urandom, $urandom};
        n = {$urandom, $urandom, $urandom, $urandom};
        a = {8'($urandom), $urandom};
        d = {8'($urandom), $urandom, $urandom, $urandom};
        ready_delay = 12;
        run_op(1'b0, k, n, a, d, 10, 1'b1, rd, rt, re, wc);
        check_result("backpressure", rd, rt, re, ref_text(k, n, a, d), ref_tag(1'b0, k, n, a, d));
    endtask

    task automatic test_timeout();
        logic [Y-1:0] rd; logic [127:0] rt; logic re; int wc;
        no_ready = 1'b1;
        run_op(1'b0, VEC_KEY, VEC_NONCE, VEC_AD, VEC_DATA, 2, 1'b0, rd, rt, re, wc);
        no_ready = 1'b0;
        checks++;
        if (re !== 1'b1) begin fails++; $display("FAIL timeout_err: got %b want 1", re); end
        checks++;
        if (rd !== '0 || rt !== '0) begin fails++; $display("FAIL timeout_res: data %h tag %h want 0", rd, rt); end
        checks++;
        if (wc !== 4096) begin fails++; $display("FAIL timeout_len: got %0d want 4096", wc); end
    endtask

    task automatic test_reset_mid_load();
        logic [Y-1:0] rd; logic [127:0] rt; logic re; int wc, w;
        ready_delay = 3;
        cmd_valid = 1'b1; cmd_decrypt = 1'b0;
        cmd_key = VEC_KEY; cmd_nonce = VEC_NONCE; cmd_ad = VEC_AD; cmd_data = VEC_DATA;
        @(negedge clk);
        cmd_valid = 1'b0;
        w = 0;
        while (core_rst !== 1'b0 && w < 20) begin @(negedge clk); w++; end
        repeat (50) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (core_rst !== 1'b1 || res_valid !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b0)
            begin fails++; $display("FAIL midload_ctl: core_rst %b valid %b busy %b ready %b want 1 0 0 0", core_rst, res_valid, busy, cmd_ready); end
        checks++;
        if ({core_key_si, core_nonce_si, core_ad_si, core_data_si, core_start} !== 5'b0)
            begin fails++; $display("FAIL midload_lines: got %b want 00000", {core_key_si, core_nonce_si, core_ad_si, core_data_si, core_start}); end
        checks++;
        if (res_data !== '0) begin fails++; $display("FAIL midload_res: got %h want 0", res_data); end
        rst = 1'b0;
        @(negedge clk);
        run_op(1'b0, VEC_KEY, VEC_NONCE, VEC_AD, VEC_DATA, 0, 1'b0, rd, rt, re, wc);
        check_result("after_reset", rd, rt, re, ct_rec, t_rec);
    endtask

    task automatic test_random();
        logic [Y-1:0] rd, d; logic [127:0] rt, n; logic [K-1:0] k; logic [L-1:0] a;
        logic re, dec; int wc;
        for (int i = 0; i < 6; i++) begin
            k = {$urandom, $urandom, $urandom, $urandom};
            n = {$urandom, $urandom, $urandom, $urandom};
            a = {8'($urandom), $urandom};
            d = {8'($urandom), $urandom, $urandom, $urandom};
            dec = 1'($urandom_range(0, 1));
            ready_delay = $urandom_range(0, 20);
            run_op(dec, k, n, a, d, $urandom_range(0, 3), 1'($urandom_range(0, 1)), rd, rt, re, wc);
            check_result("random", rd, rt, re, ref_text(k, n, a, d), ref_tag(dec, k, n, a, d));
        end
    endtask

    task automatic test_back_to_back();
        logic [Y-1:0] rd; logic [127:0] rt; logic re; int wc;
        ready_delay = 1;
        run_op(1'b0, VEC_KEY, VEC_NONCE, VEC_AD, VEC_DATA, 0, 1'b0, rd, rt, re, wc);
        check_result("b2b_enc", rd, rt, re, ct_rec, t_rec);
        run_op(1'b1, VEC_KEY, VEC_NONCE, VEC_AD, ct_rec, 0, 1'b0, rd, rt, re, wc);
        check_result("b2b_dec", rd, rt, re, VEC_DATA, t_rec);
    endtask

    initial begin
        test_reset();
        test_encrypt();
        test_decrypt();
        test_backpressure();
        test_timeout();
        test_reset_mid_load();
        test_random();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded 100000 cycles");
        $fatal(1, "watchdog expired");
    end

endmodule
